// File: rtl/spi_reg_bridge.sv
// Command decoder and register bank on the parallel side of an SPI slave.
// Byte 0 selects read/write and a start address; following bytes stream data in or out.
module spi_reg_bridge #(
    parameter int          NUM_REGS = 16,
    parameter logic [7:0]  VERSION  = 8'hA1
) (
    input  logic                    i_sys_clk,
    input  logic                    i_sys_rst_n,
    input  logic                    i_ssn,
    input  logic [7:0]              i_rx_data,
    input  logic                    i_rx_ready,
    input  logic                    i_tx_ready,
    output logic                    o_csn,
    output logic                    o_rd,
    output logic                    o_wr,
    output logic [7:0]              o_tx_data,
    output logic [8*NUM_REGS-1:0]   o_regs,
    output logic                    o_reg_wr_strobe,
    output logic [6:0]              o_reg_wr_addr,
    output logic                    o_tx_overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WDATA = 2'd1,
        RTURN = 2'd2,
        RDATA = 2'd3
    } state_t;

    state_t                  state_r;
    logic                    ssn_meta_r;
    logic                    ssn_sync_r;
    logic [1:0]              sync_vld_r;
    logic                    armed_r;
    logic                    rx_prev_r;
    logic [6:0]              addr_r;
    logic                    tx_pend_r;
    logic [8*NUM_REGS-1:0]   regs_r;
    logic [7:0]              tx_data_r;
    logic                    rd_r;
    logic                    csn_r;
    logic                    wr_strobe_r;
    logic [6:0]              wr_addr_r;
    logic                    overrun_r;

    logic                    ssn_s;
    logic                    byte_event_s;

    // Read mux: bank registers, then the version byte at the top address, else zero.
    function automatic logic [7:0] rd_byte(input logic [6:0] a, input logic [8*NUM_REGS-1:0] bank);
        logic [7:0] v;
        if (a == 7'h7F) begin
            v = VERSION;
        end else begin
            v = 8'h00;
        end
        for (int k = 0; k < NUM_REGS; k++) begin
            if (a == 7'(k)) begin
                v = bank[8*k +: 8];
            end
        end
        return v;
    endfunction

    assign ssn_s = ssn_sync_r;
    // armed_r blocks bytes after a reset until a real deselect has been seen.
    assign byte_event_s    = i_rx_ready & ~rx_prev_r & ~ssn_s & armed_r;
    assign o_wr            = tx_pend_r & i_tx_ready;
    assign o_csn           = csn_r;
    assign o_rd            = rd_r;
    assign o_tx_data       = tx_data_r;
    assign o_regs          = regs_r;
    assign o_reg_wr_strobe = wr_strobe_r;
    assign o_reg_wr_addr   = wr_addr_r;
    assign o_tx_overrun    = overrun_r;

    // Synchronizer, byte-event detection, frame FSM and register bank.
    always_ff @(posedge i_sys_clk) begin
        if (!i_sys_rst_n) begin
            state_r     <= IDLE;
            ssn_meta_r  <= 1'b1;
            ssn_sync_r  <= 1'b1;
            sync_vld_r  <= 2'b00;
            armed_r     <= 1'b0;
            rx_prev_r   <= 1'b1;
            addr_r      <= 7'h00;
            tx_pend_r   <= 1'b0;
            regs_r      <= '0;
            tx_data_r   <= 8'h00;
            rd_r        <= 1'b0;
            csn_r       <= 1'b1;
            wr_strobe_r <= 1'b0;
            wr_addr_r   <= 7'h00;
            overrun_r   <= 1'b0;
        end else begin
            ssn_meta_r  <= i_ssn;
            ssn_sync_r  <= ssn_meta_r;
            sync_vld_r  <= {sync_vld_r[0], 1'b1};
            rx_prev_r   <= i_rx_ready;
            csn_r       <= 1'b0;
            rd_r        <= byte_event_s;
            wr_strobe_r <= 1'b0;
            overrun_r   <= 1'b0;

            if (ssn_s && sync_vld_r[1]) begin
                armed_r <= 1'b1;
            end else begin
                armed_r <= armed_r;
            end

            if (o_wr) begin
                tx_pend_r <= 1'b0;
            end else begin
                tx_pend_r <= tx_pend_r;
            end

            if (ssn_s) begin
                state_r   <= IDLE;
                tx_pend_r <= 1'b0;
            end else if (byte_event_s) begin
                case (state_r)
                    IDLE: begin
                        if (i_rx_data[7]) begin
                            addr_r  <= i_rx_data[6:0];
                            state_r <= WDATA;
                        end else begin
                            tx_data_r <= rd_byte(i_rx_data[6:0], regs_r);
                            addr_r    <= i_rx_data[6:0] + 7'd1;
                            tx_pend_r <= 1'b1;
                            overrun_r <= tx_pend_r & ~o_wr;
                            state_r   <= RTURN;
                        end
                    end
                    WDATA: begin
                        // Out-of-range addresses fall through the loop: byte dropped, no strobe.
                        for (int k = 0; k < NUM_REGS; k++) begin
                            if (addr_r == 7'(k)) begin
                                regs_r[8*k +: 8] <= i_rx_data;
                                wr_strobe_r      <= 1'b1;
                                wr_addr_r        <= addr_r;
                            end
                        end
                        addr_r  <= addr_r + 7'd1;
                        state_r <= WDATA;
                    end
                    RTURN, RDATA: begin
                        tx_data_r <= rd_byte(addr_r, regs_r);
                        addr_r    <= addr_r + 7'd1;
                        tx_pend_r <= 1'b1;
                        overrun_r <= tx_pend_r & ~o_wr;
                        state_r   <= RDATA;
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: stimulus pushes expected write/tx/overrun
// events into queues; a monitor pops and compares as the DUT produces them.
module tb_spi_reg_bridge;

    localparam int NR = 16;

    logic            i_sys_clk;
    logic            i_sys_rst_n;
    logic            i_ssn;
    logic [7:0]      i_rx_data;
    logic            i_rx_ready;
    logic            i_tx_ready;
    logic            o_csn;
    logic            o_rd;
    logic            o_wr;
    logic [7:0]      o_tx_data;
    logic [8*NR-1:0] o_regs;
    logic            o_reg_wr_strobe;
    logic [6:0]      o_reg_wr_addr;
    logic            o_tx_overrun;

    spi_reg_bridge #(.NUM_REGS(NR), .VERSION(8'hA1)) dut (
        .i_sys_clk       (i_sys_clk),
        .i_sys_rst_n     (i_sys_rst_n),
        .i_ssn           (i_ssn),
        .i_rx_data       (i_rx_data),
        .i_rx_ready      (i_rx_ready),
        .i_tx_ready      (i_tx_ready),
        .o_csn           (o_csn),
        .o_rd            (o_rd),
        .o_wr            (o_wr),
        .o_tx_data       (o_tx_data),
        .o_regs          (o_regs),
        .o_reg_wr_strobe (o_reg_wr_strobe),
        .o_reg_wr_addr   (o_reg_wr_addr),
        .o_tx_overrun    (o_tx_overrun)
    );

    int n_vec  = 0;
    int n_err  = 0;
    int rd_exp = 0;
    int rd_seen = 0;

    logic [14:0] wr_q[$];
    logic [7:0]  tx_q[$];
    logic        ov_q[$];
    logic [8*NR-1:0] bank_m;

    initial i_sys_clk = 1'b0;
    always #5 i_sys_clk = ~i_sys_clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [8*NR-1:0] act, input logic [8*NR-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_sys_clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit counted);
        i_rx_data  = b;
        i_rx_ready = 1'b1;
        tick(2);
        i_rx_ready = 1'b0;
        tick(2);
        if (counted) rd_exp++;
    endtask

    task automatic frame_start();
        i_ssn = 1'b0;
        tick(3);
    endtask

    task automatic frame_end();
        i_ssn = 1'b1;
        tick(4);
        chk("rd_pulses", 128'(rd_seen), 128'(rd_exp));
    endtask

    task automatic exp_wr(input logic [6:0] a, input logic [7:0] d);
        wr_q.push_back({a, d});
        bank_m[8*a +: 8] = d;
    endtask

    // Monitor: compares every DUT-produced event against the head of its queue.
    always @(negedge i_sys_clk) begin
        if (o_rd) rd_seen++;
        if (o_reg_wr_strobe) begin
            if (wr_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_strobe: got addr %h expected none", o_reg_wr_addr);
            end else begin
                logic [14:0] e;
                e = wr_q.pop_front();
                chk("wr_addr", 128'(o_reg_wr_addr), 128'(e[14:8]));
                chk("wr_data", 128'(o_regs[8*e[14:8] +: 8]), 128'(e[7:0]));
            end
        end
        if (o_wr) begin
            if (tx_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_wr: got %h expected none", o_tx_data);
            end else begin
                logic [7:0] t;
                t = tx_q.pop_front();
                chk("tx_data", 128'(o_tx_data), 128'(t));
            end
        end
        if (o_tx_overrun) begin
            if (ov_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_overrun: got 1 expected 0");
            end else begin
                void'(ov_q.pop_front());
                n_vec++;
            end
        end
    end

    initial begin
        i_sys_rst_n = 1'b0;
        i_ssn       = 1'b1;
        i_rx_data   = 8'h00;
        i_rx_ready  = 1'b0;
        i_tx_ready  = 1'b0;
        bank_m      = '0;
        tick(3);
        chk("rst_csn", 128'(o_csn), 128'(1'b1));
        chk("rst_regs", o_regs, '0);
        chk("rst_tx_data", 128'(o_tx_data), 128'(8'h00));
        chk("rst_wr_addr", 128'(o_reg_wr_addr), 128'(7'h00));
        chk("rst_strobes", 128'({o_rd, o_wr, o_reg_wr_strobe, o_tx_overrun}), 128'(4'b0000));
        i_sys_rst_n = 1'b1;
        tick(1);
        chk("csn_after_rst", 128'(o_csn), 128'(1'b0));
        tick(3);

        // Write burst to reg2, reg3.
        frame_start();
        send_byte(8'h82, 1'b1);
        exp_wr(7'd2, 8'h11); send_byte(8'h11, 1'b1);
        exp_wr(7'd3, 8'h22); send_byte(8'h22, 1'b1);
        frame_end();
        chk("last_wr_addr", 128'(o_reg_wr_addr), 128'(7'd3));

        // Preload reg5/reg6, then read them back through the turnaround.
        frame_start();
        send_byte(8'h85, 1'b1);
        exp_wr(7'd5, 8'h5A); send_byte(8'h5A, 1'b1);
        exp_wr(7'd6, 8'hA5); send_byte(8'hA5, 1'b1);
        frame_end();
        i_tx_ready = 1'b1;
        frame_start();
        tx_q.push_back(8'h5A); send_byte(8'h05, 1'b1);
        tx_q.push_back(8'hA5); send_byte(8'hC3, 1'b1);
        tx_q.push_back(bank_m[8*7 +: 8]); send_byte(8'h3C, 1'b1);
        tx_q.push_back(bank_m[8*8 +: 8]); send_byte(8'hFF, 1'b1);
        frame_end();

        // Out-of-range write is dropped; version and unmapped reads.
        frame_start();
        send_byte(8'h90, 1'b1);
        send_byte(8'hFF, 1'b1);
        frame_end();
        chk("bank_unchanged", o_regs, bank_m);
        frame_start();
        tx_q.push_back(8'hA1); send_byte(8'h7F, 1'b1);
        tx_q.push_back(bank_m[7:0]); send_byte(8'h00, 1'b1);
        frame_end();
        frame_start();
        tx_q.push_back(8'h00); send_byte(8'h20, 1'b1);
        frame_end();

        // Address wraps from 0x7F to reg0.
        frame_start();
        send_byte(8'hFF, 1'b1);
        send_byte(8'h33, 1'b1);
        exp_wr(7'd0, 8'h44); send_byte(8'h44, 1'b1);
        frame_end();
        chk("bank_after_wrap", o_regs, bank_m);

        // Two loads with no tx acceptance: exactly one overrun.
        i_tx_ready = 1'b0;
        frame_start();
        send_byte(8'h01, 1'b1);
        ov_q.push_back(1'b1); send_byte(8'h00, 1'b1);
        frame_end();
        chk("tx_after_overrun", 128'(o_tx_data), 128'(bank_m[8*2 +: 8]));

        // Aborted write frame; next read starts at its own address.
        i_tx_ready = 1'b1;
        frame_start();
        send_byte(8'h83, 1'b1);
        frame_end();
        frame_start();
        tx_q.push_back(bank_m[8*1 +: 8]); send_byte(8'h01, 1'b1);
        tx_q.push_back(bank_m[8*2 +: 8]); send_byte(8'h00, 1'b1);
        tx_q.push_back(bank_m[8*3 +: 8]); send_byte(8'h00, 1'b1);
        frame_end();
        i_tx_ready = 1'b0;

        // Reset mid-write; rest of the frame is ignored.
        frame_start();
        send_byte(8'h84, 1'b1);
        exp_wr(7'd4, 8'h55); send_byte(8'h55, 1'b1);
        i_sys_rst_n = 1'b0;
        tick(1);
        chk("midrst_csn", 128'(o_csn), 128'(1'b1));
        chk("midrst_regs", o_regs, '0);
        i_sys_rst_n = 1'b1;
        bank_m = '0;
        tick(3);
        send_byte(8'h66, 1'b0);
        send_byte(8'h77, 1'b0);
        frame_end();
        chk("regs_after_ignored", o_regs, '0);
        frame_start();
        send_byte(8'h84, 1'b1);
        exp_wr(7'd4, 8'h77); send_byte(8'h77, 1'b1);
        frame_end();
        chk("bank_after_reset_frame", o_regs, bank_m);

        tick(2);
        chk("wr_q_drained", 128'(wr_q.size()), 128'(0));
        chk("tx_q_drained", 128'(tx_q.size()), 128'(0));
        chk("ov_q_drained", 128'(ov_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
